iterative_muldiv_unit: RTL and testbench
========================================

Name: iterative_muldiv_unit

Overview:
- Multi-cycle execution unit for the RV32M subset (`mul`, `div`), directly downstream of the ALU decoder.
- Consumes the 4-bit ALUOp code and the two ALU source operands. Runs a 32-iteration shift-add multiply or restoring divide.
- Stalls the core through `Stall` while it works, and presents `Result` on the single cycle in which `Done` is high.
- The single-cycle ALU keeps handling every other ALUOp; this block ignores them.

Parameters:
- `XLEN`, 32, operand/result width. Iteration count equals `XLEN`; counter width is clog2(`XLEN`)+1.
- `ALU_MUL`, 4'd7, ALUOp code selecting multiply (shared package constant).
- `ALU_DIV`, 4'd8, ALUOp code selecting signed divide (shared package constant).

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  synchronous active-low reset
- `Start`  in  1  instruction in execute requests this unit; held high by the core while stalled
- `ALUOp`  in  4  operation code from the ALU decoder
- `SrcA`  in  XLEN  rs1 value (multiplicand / dividend)
- `SrcB`  in  XLEN  rs2 value (multiplier / divisor)
- `Result`  out  XLEN  registered result, valid while `Done`=1
- `Done`  out  1  registered, one-cycle completion pulse
- `Busy`  out  1  registered, high in RUN and FIX
- `Stall`  out  1  combinational PC/pipeline hold

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - While `rst_n`=0 at a rising edge: state=IDLE, `Result`=0, `Done`=0, `Busy`=0, counter=0, internal accumulators=0.
  - Reset mid-operation aborts the operation with no `Done` pulse.
- Accept condition: accept = state==IDLE & `Start` & (`ALUOp`==`ALU_MUL` | `ALUOp`==`ALU_DIV`). Any other ALUOp is ignored; the unit stays IDLE with `Stall`=0.
- `Stall` = accept | state==RUN | state==FIX. It is 0 in DONE, so the core writes back `Result` and advances the PC at the end of the DONE cycle.
- States:
  - IDLE: on accept, latch the op and operands, clear the counter, go to RUN. For DIV with `SrcB`==0, instead set `Result`=0xFFFFFFFF and go directly to DONE.
  - RUN: one iteration per cycle. After iteration 32 (counter==XLEN-1), go to FIX.
    - MUL: unsigned shift-add on the raw bit patterns; keep the low XLEN bits only. This is correct for signed `mul`.
    - DIV: restoring division on magnitudes |A| and |B|. The quotient is built MSB first.
  - FIX:
    - MUL: `Result` = accumulator.
    - DIV: `Result` = quotient, negated (two's complement) if sign(A) XOR sign(B). This gives truncation toward zero.
    - Go to DONE.
  - DONE: `Done`=1 for exactly this cycle; unconditionally return to IDLE. `Start` is not sampled here, so the still-asserted request cannot re-trigger.
- Latency:
  - Accept edge is E0. Iterations run on edges E1..E32. FIX→DONE happens at E33, so `Done` is high during the cycle after E33.
  - Total stall is 34 cycles including the accept cycle.
  - Div-by-zero path: `Done` is high in the cycle after E0; stall is 1 cycle.
- `Result` holds its value until the next FIX or fast-path load. `Busy` is 0 in IDLE and DONE.
- Arithmetic corner cases:
  - Overflow 0x80000000 / 0xFFFFFFFF: |A|=2^31 fits in the XLEN-bit unsigned magnitude, quotient magnitude 2^31, negation skipped (signs equal) → 0x80000000, per RISC-V spec. No special path.
  - MUL overflow wraps modulo 2^XLEN.
- Operand changes on `SrcA`/`SrcB`/`ALUOp` after accept have no effect; the latched copies are used.
- Back-to-back M instructions: the next accept occurs in the IDLE cycle after DONE, earliest E35.

Decomposition:
- Shared package (also used by the ALU decoder):
  - ALUOp localparams `ALU_ADD`..`ALU_DIV`, `ALU_NA`
  - state encoding IDLE=0, RUN=1, FIX=2, DONE=3
  - `XLEN`
- Single module; FSM and datapath are small enough to stay together. No sub-module.

Test Plan:
- `ALUOp`=7, `SrcA`=7, `SrcB`=6, `Start` held → `Stall`=1 for 34 cycles, `Done` pulse once, `Result`=0x0000002A, then IDLE.
- `ALUOp`=7, `SrcA`=0xFFFFFFFD (-3), `SrcB`=5 → `Result`=0xFFFFFFF1 (-15); separate run with 0x00010000 × 0x00010000 → `Result`=0x00000000 (wrap).
- `ALUOp`=8, `SrcA`=0xFFFFFFF9 (-7), `SrcB`=2 → `Result`=0xFFFFFFFD (-3); `SrcA`=100, `SrcB`=0xFFFFFFF9 → `Result`=0xFFFFFFF2 (-14).
- `ALUOp`=8, `SrcB`=0, `SrcA`=1234 → `Done` in the cycle after accept, `Result`=0xFFFFFFFF, `Stall` 1 cycle. Then `SrcA`=0x80000000, `SrcB`=0xFFFFFFFF → `Result`=0x80000000 after the full 34-cycle stall.
- `ALUOp`=0 (add) with `Start`=1 → `Stall`=0, `Busy`=0, `Done`=0 indefinitely; `Result` unchanged.
- Start MUL, drop `rst_n` at cycle 10 → next cycle IDLE, `Done`=0, `Busy`=0, `Result`=0. A subsequent MUL 3×3 yields 9 with normal latency.

Source files
------------

// File: rtl/iterative_muldiv_unit_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the execute stage: ALU operation codes (also used by
// the ALU decoder), the multiply/divide unit state encoding, and the datapath
// width.
package iterative_muldiv_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;
    localparam logic [3:0] ALU_DIV = 4'd8;
    localparam logic [3:0] ALU_NA  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/iterative_muldiv_unit.sv
`timescale 1ns/1ps
// Iterative RV32M execution unit (mul, div). One shift-add or restoring-divide
// step per cycle over XLEN cycles; holds the core with Stall while working.
//
// Ports:
//   clk    - core clock, rising edge
//   rst_n  - synchronous active-low reset
//   Start  - instruction in execute requests this unit (held while stalled)
//   ALUOp  - operation code from the ALU decoder
//   SrcA   - rs1 (multiplicand / dividend)
//   SrcB   - rs2 (multiplier / divisor)
//   Result - registered result, valid while Done=1
//   Done   - registered one-cycle completion pulse
//   Busy   - registered, high in RUN and FIX
//   Stall  - combinational PC/pipeline hold
module iterative_muldiv_unit
    import iterative_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [3:0]      ALUOp,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] Result,
    output logic            Done,
    output logic            Busy,
    output logic            Stall
);

    muldiv_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             neg;
    // acc: product (MUL) / partial remainder (DIV)
    // opa: shifted multiplicand (MUL) / dividend shifting out, quotient shifting in (DIV)
    // opb: multiplier shifting right (MUL) / divisor magnitude (DIV)
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;

    logic             accept;
    logic [XLEN-1:0]  rem_shift;
    logic [XLEN:0]    diff;

    always_comb begin
        accept    = (state == IDLE) && Start && (ALUOp == ALU_MUL || ALUOp == ALU_DIV);
        Stall     = accept || (state == RUN) || (state == FIX);
        // Remainder stays below the divisor (<= 2^31), so its MSB is always
        // zero and dropping it on the shift loses nothing.
        rem_shift = {acc[XLEN-2:0], opa[XLEN-1]};
        diff      = {1'b0, rem_shift} - {1'b0, opb};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            neg    <= 1'b0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            Result <= '0;
            Done   <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (accept) begin
                        op_div <= (ALUOp == ALU_DIV);
                        cnt    <= '0;
                        acc    <= '0;
                        if (ALUOp == ALU_DIV && SrcB == '0) begin
                            Result <= '1;
                            Done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            Busy  <= 1'b1;
                            state <= RUN;
                            if (ALUOp == ALU_DIV) begin
                                opa <= magnitude(SrcA);
                                opb <= magnitude(SrcB);
                                neg <= SrcA[XLEN-1] ^ SrcB[XLEN-1];
                            end else begin
                                opa <= SrcA;
                                opb <= SrcB;
                                neg <= 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (op_div) begin
                        // diff[XLEN] set means the trial subtraction borrowed:
                        // keep the shifted remainder and shift in a 0 quotient bit.
                        acc <= diff[XLEN] ? rem_shift : diff[XLEN-1:0];
                        opa <= {opa[XLEN-2:0], ~diff[XLEN]};
                    end else begin
                        acc <= acc + (opb[0] ? opa : '0);
                        opa <= {opa[XLEN-2:0], 1'b0};
                        opb <= {1'b0, opb[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        Result <= neg ? (~opa + 1'b1) : opa;
                    end else begin
                        Result <= acc;
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for iterative_muldiv_unit: the stimulus pushes the
// hand-computed result and stall length of each operation; a monitor pops and
// compares on every Done pulse.
module tb_iterative_muldiv_unit;
    import iterative_muldiv_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            Start = 1'b0;
    logic [3:0]      ALUOp = ALU_ADD;
    logic [XLEN-1:0] SrcA = '0;
    logic [XLEN-1:0] SrcB = '0;
    logic [XLEN-1:0] Result;
    logic            Done;
    logic            Busy;
    logic            Stall;

    typedef struct {
        logic [XLEN-1:0] res;
        int              stall;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    iterative_muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .ALUOp  (ALUOp),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Result (Result),
        .Done   (Done),
        .Busy   (Busy),
        .Stall  (Stall)
    );

    always #5 clk = ~clk;

    // Monitor: counts stall cycles and checks every completion against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt = 0;
            end else begin
                if (Stall) stall_cnt++;
                if (Done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: Result=%h with no pending operation", Result);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checks++;
                        if (Result !== e.res) begin
                            errors++;
                            $display("FAIL %s result: got %h expected %h", e.name, Result, e.res);
                        end
                        checks++;
                        if (stall_cnt != e.stall) begin
                            errors++;
                            $display("FAIL %s stall: got %0d cycles expected %0d", e.name, stall_cnt, e.stall);
                        end
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Issue one M operation and hold Start until Done; scramble the operands
    // after the accept edge to show the latched copies are used.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] res, input int stall);
        exp_t e;
        bit   seen;
        e.res = res; e.stall = stall; e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        Start = 1'b1; ALUOp = op; SrcA = a; SrcB = b;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                SrcA = 32'h1357_9BDF; SrcB = 32'h0000_0003;
                if (stall > 1) check({name, " busy"}, {31'b0, Busy}, 32'd1);
            end
            if (Done) begin
                seen = 1;
                break;
            end
        end
        Start = 1'b0; ALUOp = ALU_NA;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: Done not seen within 100 cycles, expected 1", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", Result, 32'h0);
        check("reset_flags", {29'b0, Done, Busy, Stall}, 32'h0);
        rst_n = 1'b1;

        do_op("mul_7x6",     ALU_MUL, 32'd7,          32'd6,          32'h0000_002A, 34);
        do_op("mul_neg3x5",  ALU_MUL, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 34);
        do_op("mul_wrap",    ALU_MUL, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 34);
        do_op("div_neg7_2",  ALU_DIV, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34);
        do_op("div_100_neg7",ALU_DIV, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2, 34);
        do_op("div_by_zero", ALU_DIV, 32'd1234,       32'd0,          32'hFFFF_FFFF, 1);
        do_op("div_overflow",ALU_DIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 34);

        // Non-M op with Start held: unit must stay idle and keep its result.
        @(posedge clk); #1;
        Start = 1'b1; ALUOp = ALU_ADD; SrcA = 32'd5; SrcB = 32'd6;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("add_ignored_flags", {29'b0, Done, Busy, Stall}, 32'h0);
        end
        check("add_result_held", Result, 32'h8000_0000);
        Start = 1'b0;

        // Reset in the middle of a multiply: no Done, everything cleared.
        @(posedge clk); #1;
        Start = 1'b1; ALUOp = ALU_MUL; SrcA = 32'd11; SrcB = 32'd13;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0; Start = 1'b0;
        @(posedge clk); #1;
        check("abort_result", Result, 32'h0);
        check("abort_flags", {29'b0, Done, Busy, Stall}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", {31'b0, Done}, 32'h0);

        do_op("mul_3x3_after_reset", ALU_MUL, 32'd3, 32'd3, 32'h0000_0009, 34);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
